// File: rtl/stream_argmax_pkg.sv
// Shared definitions for the word-recognition (wrd) stream chain:
// default datapath widths and the argmax receiver state encoding.
package stream_argmax_pkg;

    localparam int WRD_BW = 32;
    localparam int WRD_IW = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/stream_argmax.sv
// Terminal argmax receiver: tracks the running maximum of a signed score frame
// and presents {index, score, length error} on a registered valid/ready output.
module stream_argmax
    import stream_argmax_pkg::*;
#(
    parameter int BW = WRD_BW,
    parameter int IW = WRD_IW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [BW-1:0] data_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic [IW-1:0]        class_o,
    output logic signed [BW-1:0] max_o,
    output logic                 err_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam logic [IW:0] CNT_MAX = {1'b1, {IW{1'b0}}};

    state_t               state, state_n;
    logic [IW:0]          count;
    logic                 first;
    logic                 err_r, err_n;
    logic signed [BW-1:0] max_r, max_n;
    logic [IW-1:0]        idx_r, idx_n;
    logic                 accept;
    logic                 load;

    // ready depends only on registered state, never on ready_i
    assign ready_o = (state == ACCUM);
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ACCUM;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        max_n   = max_r;
        idx_n   = idx_r;
        err_n   = err_r;
        load    = 1'b0;
        case (state)
            ACCUM: begin
                if (accept) begin
                    // beats past the index range are counted as errors, not compared
                    if (count == CNT_MAX) begin
                        err_n = 1'b1;
                    end else if (first) begin
                        max_n = data_i;
                        idx_n = '0;
                    end else if (data_i > max_r) begin
                        max_n = data_i;
                        idx_n = count[IW-1:0];
                    end
                    if (last_i) begin
                        state_n = HOLD;
                        load    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (valid_o && ready_i) state_n = ACCUM;
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count   <= '0;
            first   <= 1'b1;
            err_r   <= 1'b0;
            max_r   <= '0;
            idx_r   <= '0;
            valid_o <= 1'b0;
            class_o <= '0;
            max_o   <= '0;
            err_o   <= 1'b0;
        end else begin
            if (accept) begin
                max_r <= max_n;
                idx_r <= idx_n;
            end
            if (load) begin
                // result takes the values already updated by the last beat
                class_o <= idx_n;
                max_o   <= max_n;
                err_o   <= err_n;
                valid_o <= 1'b1;
                count   <= '0;
                first   <= 1'b1;
                err_r   <= 1'b0;
            end else begin
                if (accept) begin
                    count <= (count == CNT_MAX) ? count : count + 1'b1;
                    first <= 1'b0;
                    err_r <= err_n;
                end
                if (state == HOLD && valid_o && ready_i) valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/stream_argmax.md
Name: stream_argmax

Overview:
- Terminal receiver of the word-recognition datapath's valid/last/ready stream, i.e. the consuming end of the rectified/pooled/FC score stream.
- Accepts one frame of signed BW-bit class scores, one per beat, terminated by last.
- Emits one result per frame: the index of the maximum score, the score itself and a length-error flag, presented on a registered valid/ready output handshake.

Parameters:
- BW, 32, score width in bits (signed two's complement).
- IW, 8, class index width; maximum frame length is 2^IW beats.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  BW  signed score beat.
- valid_i  in  1  input beat valid.
- last_i  in  1  marks final beat of frame; sampled only on accepted beats.
- ready_o  out  1  block can accept an input beat.
- class_o  out  IW  index of the maximum score in the frame.
- max_o  out  BW  signed maximum score.
- err_o  out  1  frame longer than 2^IW beats.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.

Behaviour:
- Reset (rst_i high at an edge):
  - state=ACCUM, count=0, first=1.
  - valid_o=0, class_o=0, max_o=0, err_o=0.
  - ready_o is 1 from the first cycle after reset.
  - Reset mid-frame or mid-HOLD discards all partial or pending results.
- Accept rule: a beat is accepted when valid_i && ready_o. ready_o = (state==ACCUM), decoded from registered state only; no combinational path from ready_i.
- ACCUM state, on an accepted beat:
  - If first=1: max<=data_i, idx<=0, first<=0.
  - Else if count<2^IW and data_i > max (signed, strict): max<=data_i, idx<=count.
  - Ties keep the earlier (lower) index.
  - count<=count+1, saturating at 2^IW. count is IW+1 bits wide.
  - If count==2^IW at acceptance: the beat is not compared and err<=1 (sticky for the frame).
- End of frame, when the accepted beat has last_i=1:
  - The result uses the max/idx/err updated by that same beat.
  - class_o/max_o/err_o are loaded and valid_o<=1 in the next cycle.
  - state<=HOLD; count, first and err are cleared for the next frame.
  - Latency: valid_o rises exactly 1 cycle after the last beat is accepted.
- HOLD state:
  - ready_o=0; input is back-pressured. valid_i with no accept is legal and ignored.
  - class_o/max_o/err_o/valid_o are held stable until valid_o && ready_i.
  - On that handshake: valid_o<=0, state<=ACCUM, and ready_o=1 the following cycle.
  - Minimum frame-to-frame gap is therefore 1 bubble cycle after the result handshake.
- Single-beat frame (last_i on the first beat): class_o=0, max_o=data_i.
- All-negative frames are valid; max_o is negative. Most-negative value (-2^(BW-1)) handled correctly.
- valid_i without last_i continues accumulation; frame boundaries are defined only by last_i.
- State encoding: 1 bit (ACCUM=0, HOLD=1).

Decomposition:
- Shared wrd package: state encoding constants (ACCUM, HOLD) and the default BW/IW used by the wrd chain.
- No sub-module: the compare/update datapath and the FSM fit in one module.
- A reusable result-hold register slice (stream_hold_reg) is optional if other wrd stages need the same output-hold pattern.

Test Plan:
- Frame [3, -7, 12, 12, 5] with last on beat 4, ready_i=1 -> valid_o one cycle after beat 4; class_o=2 (tie keeps earlier), max_o=12, err_o=0; ready_o low for HOLD and back high the cycle after the handshake.
- Frame [-5, -2, -9] -> class_o=1, max_o=-2; frame [-2^31] with IW=8 single beat -> class_o=0, max_o=-2147483648.
- Hold ready_i=0 for 10 cycles after a result while valid_i is driven -> outputs stable, ready_o=0, no input consumed; results delivered in order after ready_i rises.
- IW=2, frame of 6 beats [1,2,3,4,99,0] -> class_o=3, max_o=4, err_o=1; next frame [7] -> err_o=0, class_o=0.
- Assert rst_i mid-frame after [50, 60], then send frame [1, 2] -> class_o=1, max_o=2 (pre-reset beats ignored); reset during HOLD drops valid_o next cycle.
- Random valid_i gaps over 1000 random frames versus a scoreboard model -> every result matches, with exactly one valid_o handshake per last beat.
